// File: rtl/tpu_feed_pkg.sv
// Shared definitions for the skewed A-operand feeder.
//
// Contents:
//   DEF_N / DEF_DW : default tile dimension and operand width
//   feed_state_e   : feeder FSM states
//   lane_sel_t     : {valid, row, col} selection for one output lane
//   lane_sel()     : maps (stream step t, lane, transpose) to a buffer element
package tpu_feed_pkg;

    localparam int DEF_N  = 8;
    localparam int DEF_DW = 16;

    // Index fields are sized for tiles up to 256 x 256.
    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_FULL   = 2'd2,
        ST_STREAM = 2'd3
    } feed_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } lane_sel_t;

    // Lane i lags lane 0 by i steps, so at step t it carries element k = t - i
    // of its diagonal. Normal mode reads buf[k][i], transpose reads buf[i][k].
    function automatic lane_sel_t lane_sel(input int t, input int lane, input int n,
                                           input logic tr);
        lane_sel_t sel;
        int        k;
        k   = t - lane;
        sel = '0;
        if (k >= 0 && k < n) begin
            sel.valid = 1'b1;
            sel.row   = IDX_W'(tr ? lane : k);
            sel.col   = IDX_W'(tr ? k : lane);
        end
        return sel;
    endfunction

endpackage

// File: rtl/feed_tile_buf.sv
// N x N register file holding one operand tile.
//
// Ports:
//   clk     : clock
//   wr_en   : write one full row this cycle
//   wr_row  : row index to write
//   wr_data : row data, element c at [c*DW +: DW]
//   rd_t    : stream step to read
//   rd_tr   : 1 = read transposed tile
//   rd_data : lane data for step rd_t, lane i at [i*DW +: DW] (0 when invalid)
//   rd_vld  : per-lane valid for step rd_t
module feed_tile_buf
    import tpu_feed_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int CW = $clog2(2*N),
    parameter int RW = $clog2(N)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [N*DW-1:0] wr_data,
    input  logic [CW-1:0]   rd_t,
    input  logic            rd_tr,
    output logic [N*DW-1:0] rd_data,
    output logic [N-1:0]    rd_vld
);

    // Contents are don't-care after reset, so the array has no reset.
    logic [DW-1:0] mem [N][N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_row][c] <= wr_data[c*DW +: DW];
            end
        end
    end

    lane_sel_t     sel;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] col_idx;

    always_comb begin
        rd_data = '0;
        rd_vld  = '0;
        sel     = '0;
        row_idx = '0;
        col_idx = '0;
        for (int i = 0; i < N; i++) begin
            sel     = lane_sel(int'(rd_t), i, N, rd_tr);
            row_idx = RW'(sel.row);
            col_idx = RW'(sel.col);
            if (sel.valid) begin
                rd_vld[i]            = 1'b1;
                rd_data[i*DW +: DW]  = mem[row_idx][col_idx];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skewed A-matrix feeder: buffers one N x N tile loaded row by row and
// streams it into N systolic row lanes with lane i delayed by i cycles.
//
// Handshake: a row transfers on a rising clk edge where ld_valid && ld_ready;
// ld_ready depends only on state, never on ld_valid.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_data : row load interface
//   start, transpose : launch streaming from FULL (transpose sampled with start)
//   stall        : freeze the stream counter and outputs
//   flush        : synchronous abort to IDLE
//   a_out, a_vld : registered lane data / per-lane valid
//   busy, tile_full, done : STREAM state, FULL state, end-of-stream pulse
module systolic_skew_feeder
    import tpu_feed_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [N*DW-1:0] ld_data,
    input  logic            start,
    input  logic            transpose,
    input  logic            stall,
    input  logic            flush,
    output logic [N*DW-1:0] a_out,
    output logic [N-1:0]    a_vld,
    output logic            busy,
    output logic            tile_full,
    output logic            done
);

    localparam int CW = $clog2(2*N);
    localparam int RW = $clog2(N);
    localparam logic [CW-1:0] T_LAST   = CW'(2*N - 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

    feed_state_e     state;
    feed_state_e     state_nxt;
    logic [RW-1:0]   row_cnt;
    logic [CW-1:0]   t_cnt;      // step currently shown on a_out
    logic            tr_q;
    logic            row_acc;
    logic            launch;
    logic            advance;
    logic            finish;
    logic [CW-1:0]   rd_t;
    logic            rd_tr;
    logic [N*DW-1:0] rd_data;
    logic [N-1:0]    rd_vld;

    assign row_acc = ld_valid && ld_ready && !flush;
    assign launch  = (state == ST_FULL) && start && !flush;
    assign advance = (state == ST_STREAM) && !stall && !flush;
    assign finish  = advance && (t_cnt == T_LAST);

    // The read mux looks one step ahead of t_cnt so step 0 is registered on
    // the start edge itself and appears the very next cycle.
    assign rd_t  = launch ? '0 : t_cnt + CW'(1);
    assign rd_tr = launch ? transpose : tr_q;

    feed_tile_buf #(
        .N  (N),
        .DW (DW),
        .CW (CW),
        .RW (RW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (row_acc),
        .wr_row  (row_cnt),
        .wr_data (ld_data),
        .rd_t    (rd_t),
        .rd_tr   (rd_tr),
        .rd_data (rd_data),
        .rd_vld  (rd_vld)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (row_acc) state_nxt = ST_LOAD;
                ST_LOAD:   if (row_acc && row_cnt == ROW_LAST) state_nxt = ST_FULL;
                ST_FULL:   if (start) state_nxt = ST_STREAM;
                ST_STREAM: if (finish) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        ld_ready  = (state == ST_IDLE) || (state == ST_LOAD);
        busy      = (state == ST_STREAM);
        tile_full = (state == ST_FULL);
    end

    // Counters and registered lane outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt <= '0;
            t_cnt   <= '0;
            tr_q    <= 1'b0;
            a_out   <= '0;
            a_vld   <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;

            if (flush) begin
                row_cnt <= '0;
            end else if (row_acc) begin
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
            end

            if (flush || finish) begin
                t_cnt <= '0;
                a_out <= '0;
                a_vld <= '0;
            end else if (launch) begin
                t_cnt <= '0;
                tr_q  <= transpose;
                a_out <= rd_data;
                a_vld <= rd_vld;
            end else if (advance) begin
                t_cnt <= t_cnt + CW'(1);
                a_out <= rd_data;
                a_vld <= rd_vld;
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=8, DW=16).
module tb_systolic_skew_feeder;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int W  = N * DW;

    localparam logic [63:0] T3_NORM = 64'h0003_0102_0201_0300;
    localparam logic [63:0] T3_TRAN = 64'h0300_0201_0102_0003;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ld_valid;
    logic          ld_ready;
    logic [W-1:0]  ld_data;
    logic          start;
    logic          transpose;
    logic          stall;
    logic          flush;
    logic [W-1:0]  a_out;
    logic [N-1:0]  a_vld;
    logic          busy;
    logic          tile_full;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .start     (start),
        .transpose (transpose),
        .stall     (stall),
        .flush     (flush),
        .a_out     (a_out),
        .a_vld     (a_vld),
        .busy      (busy),
        .tile_full (tile_full),
        .done      (done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] elem(input int r, input int c, input logic [DW-1:0] key);
        return {8'(r), 8'(c)} ^ key;
    endfunction

    function automatic logic [W-1:0] row_word(input int r, input logic [DW-1:0] key);
        logic [W-1:0] d;
        for (int c = 0; c < N; c++) d[c*DW +: DW] = elem(r, c, key);
        return d;
    endfunction

    task automatic expect_lanes(input string tag, input int t, input logic tr,
                                input logic [DW-1:0] key);
        logic [N-1:0] v;
        logic [W-1:0] d;
        int           k;
        v = '0;
        d = '0;
        for (int i = 0; i < N; i++) begin
            k = t - i;
            if (k >= 0 && k < N) begin
                v[i] = 1'b1;
                d[i*DW +: DW] = tr ? elem(i, k, key) : elem(k, i, key);
            end
        end
        check({tag, " a_vld"}, W'(a_vld), W'(v));
        check({tag, " a_out"}, a_out, d);
    endtask

    task automatic load_rows(input int first, input int count, input logic [DW-1:0] key);
        for (int r = first; r < first + count; r++) begin
            ld_valid = 1'b1;
            ld_data  = row_word(r, key);
            check("ld_ready during load", W'(ld_ready), W'(1));
            step();
        end
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    // Launch from FULL and check every cycle through the done pulse.
    task automatic run_stream(input string tag, input logic tr, input logic [DW-1:0] key,
                              input int stall_at, input int stall_len,
                              input logic chk_t3, input logic [63:0] t3_word);
        int tt;
        int held;
        start     = 1'b1;
        transpose = tr;
        step();
        start     = 1'b0;
        transpose = 1'b0;
        tt   = 0;
        held = 0;
        for (int c = 1; c <= 2*N + stall_len; c++) begin
            if (c == 2*N + stall_len) begin
                check({tag, " done pulse"}, W'(done), W'(1));
                check({tag, " a_vld end"}, W'(a_vld), '0);
                check({tag, " a_out end"}, a_out, '0);
                check({tag, " busy end"}, W'(busy), '0);
                check({tag, " ld_ready end"}, W'(ld_ready), W'(1));
            end else begin
                expect_lanes($sformatf("%s t=%0d", tag, tt), tt, tr, key);
                check({tag, " busy"}, W'(busy), W'(1));
                check({tag, " done low"}, W'(done), '0);
                check({tag, " ld_ready low"}, W'(ld_ready), '0);
                if (chk_t3 && tt == 3) check({tag, " t3 lanes"}, W'(a_out[63:0]), W'(t3_word));
                if (chk_t3 && tt == 2*N - 2 && !tr) begin
                    check({tag, " t14 lane7"}, W'(a_out[W-1 -: DW]), W'(16'h0707));
                    check({tag, " t14 vld"}, W'(a_vld), W'(8'h80));
                end
                if (tt == stall_at && held < stall_len) begin
                    stall = 1'b1;
                    held++;
                end else begin
                    stall = 1'b0;
                    tt++;
                end
            end
            step();
        end
        stall = 1'b0;
        check({tag, " done single"}, W'(done), '0);
        check({tag, " idle after"}, W'(busy), '0);
    endtask

    // Launch from FULL and advance until step `target` is on the outputs.
    task automatic start_to(input logic tr, input int target, input logic [DW-1:0] key);
        start     = 1'b1;
        transpose = tr;
        step();
        start     = 1'b0;
        transpose = 1'b0;
        for (int s = 0; s < target; s++) step();
        expect_lanes($sformatf("pre-abort t=%0d", target), target, tr, key);
    endtask

    initial begin
        reset_n   = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        start     = 1'b0;
        transpose = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        step();
        step();
        check("reset a_vld", W'(a_vld), '0);
        check("reset a_out", a_out, '0);
        check("reset busy", W'(busy), '0);
        check("reset tile_full", W'(tile_full), '0);
        check("reset done", W'(done), '0);
        check("reset ld_ready", W'(ld_ready), W'(1));
        reset_n = 1'b1;
        step();

        // ld_valid held high past the 8th row: only 8 rows are taken.
        for (int c = 0; c < N + 3; c++) begin
            ld_valid = 1'b1;
            ld_data  = (c < N) ? row_word(c, '0) : {W{1'b1}};
            check("ld_ready continuous", W'(ld_ready), W'(c < N));
            check("tile_full continuous", W'(tile_full), W'(c >= N));
            step();
        end
        ld_valid = 1'b0;
        ld_data  = '0;
        check("full busy", W'(busy), '0);
        run_stream("normal", 1'b0, '0, -1, 0, 1'b1, T3_NORM);

        load_rows(0, N, '0);
        run_stream("transpose", 1'b1, '0, -1, 0, 1'b1, T3_TRAN);

        load_rows(0, N, 16'h1111);
        run_stream("stall", 1'b0, 16'h1111, 5, 3, 1'b0, '0);

        // start during LOAD is ignored; the load then resumes at row 5.
        load_rows(0, 5, 16'h2222);
        start = 1'b1;
        step();
        start = 1'b0;
        check("early start tile_full", W'(tile_full), '0);
        check("early start busy", W'(busy), '0);
        check("early start ld_ready", W'(ld_ready), W'(1));
        load_rows(5, 3, 16'h2222);
        check("late rows tile_full", W'(tile_full), W'(1));
        run_stream("after early start", 1'b1, 16'h2222, -1, 0, 1'b0, '0);

        // flush beats start in FULL
        load_rows(0, N, 16'h3333);
        flush = 1'b1;
        start = 1'b1;
        step();
        flush = 1'b0;
        start = 1'b0;
        check("flush full busy", W'(busy), '0);
        check("flush full tile_full", W'(tile_full), '0);
        check("flush full ld_ready", W'(ld_ready), W'(1));

        // flush mid-stream with start high
        load_rows(0, N, 16'h3333);
        start_to(1'b0, 4, 16'h3333);
        flush = 1'b1;
        start = 1'b1;
        step();
        flush = 1'b0;
        start = 1'b0;
        check("flush busy", W'(busy), '0);
        check("flush a_vld", W'(a_vld), '0);
        check("flush a_out", a_out, '0);
        check("flush done", W'(done), '0);
        check("flush ld_ready", W'(ld_ready), W'(1));
        for (int s = 0; s < 3; s++) begin
            step();
            check("no done after flush", W'(done), '0);
        end
        load_rows(0, N, 16'h5A5A);
        run_stream("post flush", 1'b0, 16'h5A5A, -1, 0, 1'b0, '0);

        // async reset mid-stream
        load_rows(0, N, 16'h4444);
        start_to(1'b1, 7, 16'h4444);
        #2 reset_n = 1'b0;
        #1;
        check("async rst a_vld", W'(a_vld), '0);
        check("async rst a_out", a_out, '0);
        check("async rst busy", W'(busy), '0);
        check("async rst ld_ready", W'(ld_ready), W'(1));
        #2 reset_n = 1'b1;
        step();
        check("post rst ld_ready", W'(ld_ready), W'(1));
        check("post rst tile_full", W'(tile_full), '0);
        check("post rst done", W'(done), '0);

        // reset mid-load discards the partial tile
        load_rows(0, 3, 16'h7777);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        step();
        load_rows(0, N, 16'h6666);
        check("reload tile_full", W'(tile_full), W'(1));
        run_stream("post reset", 1'b0, 16'h6666, -1, 0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
